vector_floating_point_minmax_pipeline: RTL and testbench
========================================================

# vector_floating_point_minmax_pipeline

Parametrised, handshaked successor to the fixed two-register vector FP min/max unit. It executes vfmin/vfmax across all lanes of a VLEN-bit register at SEW 16, 32 or 64, following RISC-V V/F semantics (minimumNumber/maximumNumber). Masking, vl tail handling, the invalid flag, and a configurable pipeline depth with valid/ready back-pressure are all supported. It sits in the FP execution cluster between the operand-read stage and the writeback arbiter.

## Interface
- VLEN, 128: vector register width in bits; multiple of 64, ≥ 64.
- STAGES, 2: pipeline depth in registers, legal range 2..4.
- VLW, $clog2(VLEN/16)+1: width of vl.

- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- op_max  in  1  0 = vfmin, 1 = vfmax.
- sew  in  2  01 = 16-bit, 10 = 32-bit, 11 = 64-bit; 00 reserved.
- vl  in  VLW  active element count.
- vm  in  1  1 = unmasked; 0 = element i active only if v0[i].
- v0  in  VLEN/16  mask bits, element-indexed.
- vs2, vs1  in  VLEN  source operands.
- vd_old  in  VLEN  destination's prior value.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- vd  out  VLEN  result.
- fflags  out  5  {NV,DZ,OF,UF,NX}; only NV is ever set.

## Operation
- Element i spans bits [i*SEW +: SEW]; element count is VLEN/SEW.
- Active element: i < vl and (vm || v0[i]). Inactive or tail elements: vd element = vd_old element (undisturbed).
- Active element result:
  - Neither operand NaN: vfmin returns the smaller, vfmax the larger. -0 is treated as less than +0.
  - Exactly one operand NaN (quiet or signalling): return the other operand.
  - Both NaN: return the canonical NaN: 0x7E00 (16), 0x7FC00000 (32), 0x7FF8000000000000 (64).
- NaN detection: exponent all ones and mantissa nonzero. sNaN = NaN with mantissa MSB 0.
- NV = OR over active elements of (either operand is sNaN). Other flags are always 0.
- sew = 00: vd = vd_old, fflags = 0, handshake proceeds normally.
- vl > VLEN/SEW: clamp to VLEN/SEW.

## Timing
- Stage 1 registers all inputs. Compare/select runs between stage 1 and stage 2. Stages 3..STAGES are retiming registers on {vd, fflags}.
- Latency: an operation accepted at edge N presents out_valid at edge N+STAGES-1 when there is no back-pressure, i.e. STAGES registers including the input register.
- Global stall: advance = !out_valid || out_ready; in_ready = advance. All stage registers, including valid bits, load only when advance.
- Bubbles are not collapsed. Each stage carries its own valid bit. Throughput is 1 operation/cycle while out_ready = 1.
- out_valid, vd and fflags hold stable while out_valid && !out_ready.
- in_ready has no combinational path from in_valid. It depends combinationally on out_ready and the last-stage valid bit only.
- Reset (asynchronous, any time including mid-operation): all valid bits 0, all data registers 0. Outputs: out_valid = 0, vd = 0, fflags = 0, in_ready = 1. In-flight operations are dropped.

## Test plan
- VLEN=128, sew=10, vm=1, vl=4, op_max=0, vs2 lanes {1.0, -2.0, +0, 3.5}, vs1 lanes {2.0, -3.0, -0, 3.5} → vd lanes {0x3F800000, 0xC0400000, 0x80000000, 0x40600000}, NV=0, out_valid exactly STAGES-1 edges after acceptance.
- NaN cases, sew=11, op_max=1:
  - Lane 0: vs2 = qNaN 0x7FF8000000000001, vs1 = 1.0 → result 1.0.
  - Lane 1: vs2 = sNaN 0x7FF0000000000001, vs1 = sNaN → result 0x7FF8000000000000, NV=1.
- Mask/tail, sew=01, vl=5, vm=0, v0=0x0015, vd_old all 0xAAAA → only elements 0, 2 and 4 computed; others = 0xAAAA. An sNaN placed in masked-off element 1 leaves NV=0.
- Back-pressure: stream 6 operations back-to-back and hold out_ready=0 for 3 cycles mid-stream → in_ready drops the same cycle, no operation is lost or duplicated, and output order and values are preserved. Repeat with STAGES=2, 3 and 4.
- Reset: assert reset_n=0 while 2 operations are in flight → out_valid=0, vd=0, fflags=0, and in_ready=1 immediately (asynchronous). After release, the next operation completes with normal latency.
- Reserved sew=00 and vl=0 → vd equals vd_old bit-exactly, fflags=0, handshake completes.

Source files
------------

// File: rtl/vector_floating_point_minmax_pipeline.sv
// Vector FP min/max (RISC-V vfmin/vfmax, minimumNumber/maximumNumber) with
// masking, vl tail handling, NV flag and a STAGES-deep stall-able pipeline.
// Each 64-bit slice of the vector is handled by one lane; a lane holds
// comparators for four 16-bit, two 32-bit and one 64-bit element and picks
// the set matching sew.

// Single-element min/max select for a W-bit IEEE format.
module fp_minmax_elem #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op_max,
  output logic [W-1:0] r,
  output logic         snan
);
  localparam int MW = (W == 16) ? 10 : (W == 32) ? 23 : 52;
  localparam int EW = W - 1 - MW;
  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  logic a_nan, b_nan, a_lt_b;

  assign a_nan = (&a[W-2:MW]) && (|a[MW-1:0]);
  assign b_nan = (&b[W-2:MW]) && (|b[MW-1:0]);
  assign snan  = (a_nan && !a[MW-1]) || (b_nan && !b[MW-1]);

  // Sign-magnitude ordering; differing signs put -0 below +0 for free.
  always_comb begin
    if (a[W-1] != b[W-1]) a_lt_b = a[W-1];
    else if (!a[W-1])     a_lt_b = a[W-2:0] < b[W-2:0];
    else                  a_lt_b = a[W-2:0] > b[W-2:0];
  end

  // NaN operands lose to numbers; two NaNs collapse to the canonical NaN.
  always_comb begin
    if (a_nan && b_nan) r = QNAN;
    else if (a_nan)     r = b;
    else if (b_nan)     r = a;
    else if (op_max)    r = a_lt_b ? b : a;
    else                r = a_lt_b ? a : b;
  end
endmodule

// One 64-bit slice: per-SEW element results merged with vd_old.
module fp_minmax_lane (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [63:0] old,
  input  logic [1:0]  sew,
  input  logic        op_max,
  input  logic [3:0]  act16,
  input  logic [1:0]  act32,
  input  logic        act64,
  output logic [63:0] res,
  output logic        nv
);
  logic [3:0][15:0] r16;
  logic [3:0]       sn16;
  logic [1:0][31:0] r32;
  logic [1:0]       sn32;
  logic [63:0]      r64;
  logic             sn64;

  for (genvar k = 0; k < 4; k++) begin : g_e16
    fp_minmax_elem #(.W(16)) u_e16 (
      .a(a[16*k +: 16]), .b(b[16*k +: 16]), .op_max(op_max), .r(r16[k]), .snan(sn16[k]));
  end
  for (genvar k = 0; k < 2; k++) begin : g_e32
    fp_minmax_elem #(.W(32)) u_e32 (
      .a(a[32*k +: 32]), .b(b[32*k +: 32]), .op_max(op_max), .r(r32[k]), .snan(sn32[k]));
  end
  fp_minmax_elem #(.W(64)) u_e64 (
    .a(a), .b(b), .op_max(op_max), .r(r64), .snan(sn64));

  // Active elements take the computed value; everything else stays undisturbed.
  always_comb begin
    res = old;
    nv  = 1'b0;
    case (sew)
      2'b01: for (int k = 0; k < 4; k++) if (act16[k]) begin
        res[16*k +: 16] = r16[k];
        nv = nv | sn16[k];
      end
      2'b10: for (int k = 0; k < 2; k++) if (act32[k]) begin
        res[32*k +: 32] = r32[k];
        nv = nv | sn32[k];
      end
      2'b11: if (act64) begin
        res = r64;
        nv  = sn64;
      end
      default: ;
    endcase
  end
endmodule

module vector_floating_point_minmax_pipeline #(
  parameter int VLEN   = 128,
  parameter int STAGES = 2,
  parameter int VLW    = $clog2(VLEN/16) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_max,
  input  logic [1:0]        sew,
  input  logic [VLW-1:0]    vl,
  input  logic              vm,
  input  logic [VLEN/16-1:0] v0,
  input  logic [VLEN-1:0]   vs2,
  input  logic [VLEN-1:0]   vs1,
  input  logic [VLEN-1:0]   vd_old,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN-1:0]   vd,
  output logic [4:0]        fflags
);
  localparam int NL = VLEN / 64;

  typedef struct packed {
    logic               op_max;
    logic [1:0]         sew;
    logic [VLW-1:0]     vl;
    logic               vm;
    logic [VLEN/16-1:0] v0;
    logic [VLEN-1:0]    vs2;
    logic [VLEN-1:0]    vs1;
    logic [VLEN-1:0]    vd_old;
  } req_t;

  typedef struct packed {
    logic [VLEN-1:0] vd;
    logic [4:0]      fflags;
  } rsp_t;

  logic                advance;
  logic [STAGES:1]     vld_pipe;
  req_t                req_in, req_s1;
  rsp_t                rsp_cmp;
  rsp_t [STAGES:2]     rsp_pipe;
  logic [NL-1:0][63:0] lane_res;
  logic [NL-1:0]       lane_nv;

  // One global stall: nothing moves while the last stage is held.
  assign advance  = !vld_pipe[STAGES] || out_ready;
  assign in_ready = advance;
  assign req_in   = {op_max, sew, vl, vm, v0, vs2, vs1, vd_old};

  // Pipeline registers: input capture, compare result, then retiming stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      req_s1   <= '0;
      rsp_pipe <= '0;
    end else if (advance) begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], in_valid};
      req_s1      <= req_in;
      rsp_pipe[2] <= rsp_cmp;
      for (int s = 3; s <= STAGES; s++) rsp_pipe[s] <= rsp_pipe[s-1];
    end
  end

  // Element index < vl also clamps vl, since indices never reach VLEN/SEW.
  for (genvar s = 0; s < NL; s++) begin : g_lane
    logic [3:0] act16;
    logic [1:0] act32;
    logic       act64;
    for (genvar k = 0; k < 4; k++) begin : g_a16
      assign act16[k] = (VLW'(4*s+k) < req_s1.vl) && (req_s1.vm || req_s1.v0[4*s+k]);
    end
    for (genvar k = 0; k < 2; k++) begin : g_a32
      assign act32[k] = (VLW'(2*s+k) < req_s1.vl) && (req_s1.vm || req_s1.v0[2*s+k]);
    end
    assign act64 = (VLW'(s) < req_s1.vl) && (req_s1.vm || req_s1.v0[s]);

    fp_minmax_lane u_lane (
      .a(req_s1.vs2[64*s +: 64]), .b(req_s1.vs1[64*s +: 64]), .old(req_s1.vd_old[64*s +: 64]),
      .sew(req_s1.sew), .op_max(req_s1.op_max),
      .act16(act16), .act32(act32), .act64(act64),
      .res(lane_res[s]), .nv(lane_nv[s]));
  end

  // Gather lane results; only NV can ever be raised.
  always_comb begin
    rsp_cmp.vd     = lane_res;
    rsp_cmp.fflags = {|lane_nv, 4'b0000};
  end

  assign out_valid = vld_pipe[STAGES];
  assign vd        = rsp_pipe[STAGES].vd;
  assign fflags    = rsp_pipe[STAGES].fflags;
endmodule

// File: tb/tb_vector_floating_point_minmax_pipeline.sv
// Bench for vector_floating_point_minmax_pipeline: three instances with
// STAGES = 2, 3, 4 share one stimulus stream; a scoreboard per instance
// checks ordered results against a real-arithmetic reference model.
`timescale 1ns/1ps
module tb_vector_floating_point_minmax_pipeline;
  localparam int VLEN = 128;
  localparam int VLW  = 4;

  typedef struct packed {
    logic            op_max;
    logic [1:0]      sew;
    logic [VLW-1:0]  vl;
    logic            vm;
    logic [7:0]      v0;
    logic [VLEN-1:0] vs2;
    logic [VLEN-1:0] vs1;
    logic [VLEN-1:0] vd_old;
  } req_t;

  typedef struct packed {
    logic [VLEN-1:0] vd;
    logic [4:0]      ff;
  } res_t;

  typedef struct {
    req_t q;
    res_t e;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  req_t cur = '0;
  logic dut_in_valid;
  wire [2:0] in_ready_a;
  wire [2:0] out_valid_a;
  wire [VLEN-1:0] vd_a [3];
  wire [4:0] ff_a [3];

  int checks = 0;
  int errors = 0;
  res_t exp_mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr [3] = '{0, 0, 0};
  bit rand_ready = 1'b0;
  vec_t tbl [9];

  always #5 clock = ~clock;

  // An operation enters only when every instance can take it.
  assign dut_in_valid = in_valid && (&in_ready_a);

  for (genvar d = 0; d < 3; d++) begin : g_dut
    vector_floating_point_minmax_pipeline #(.VLEN(VLEN), .STAGES(d+2), .VLW(VLW)) u_dut (
      .clock(clock), .reset_n(reset_n), .in_valid(dut_in_valid), .in_ready(in_ready_a[d]),
      .op_max(cur.op_max), .sew(cur.sew), .vl(cur.vl), .vm(cur.vm), .v0(cur.v0),
      .vs2(cur.vs2), .vs1(cur.vs1), .vd_old(cur.vd_old),
      .out_valid(out_valid_a[d]), .out_ready(out_ready), .vd(vd_a[d]), .fflags(ff_a[d]));
  end

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int man_w(int w);
    return (w == 16) ? 10 : (w == 32) ? 23 : 52;
  endfunction

  function automatic logic [63:0] get_e(logic [VLEN-1:0] v, int i, int w);
    logic [VLEN-1:0] t = v >> (i*w);
    logic [63:0] m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 1);
    return t[63:0] & m;
  endfunction

  function automatic logic [VLEN-1:0] put_e(logic [VLEN-1:0] v, int i, int w, logic [63:0] x);
    logic [63:0] m64 = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 1);
    logic [VLEN-1:0] m = VLEN'(m64) << (i*w);
    return (v & ~m) | ((VLEN'(x & m64)) << (i*w));
  endfunction

  function automatic bit is_nan(logic [63:0] x, int w);
    int mw = man_w(w);
    int ew = w - 1 - mw;
    longint unsigned e = (x >> mw) & ((64'd1 << ew) - 1);
    longint unsigned m = x & ((64'd1 << mw) - 1);
    return (e == ((64'd1 << ew) - 1)) && (m != 0);
  endfunction

  function automatic bit is_snan(logic [63:0] x, int w);
    int mw = man_w(w);
    return is_nan(x, w) && (((x >> (mw - 1)) & 64'd1) == 0);
  endfunction

  function automatic bit is_inf(logic [63:0] x, int w);
    int mw = man_w(w);
    int ew = w - 1 - mw;
    longint unsigned e = (x >> mw) & ((64'd1 << ew) - 1);
    longint unsigned m = x & ((64'd1 << mw) - 1);
    return (e == ((64'd1 << ew) - 1)) && (m == 0);
  endfunction

  function automatic bit sign_of(logic [63:0] x, int w);
    return x[w-1];
  endfunction

  // Finite value of an encoding as a real (exact for all three formats).
  function automatic real to_real(logic [63:0] x, int w);
    int mw = man_w(w);
    int ew = w - 1 - mw;
    int bias = (1 << (ew - 1)) - 1;
    longint unsigned e = (x >> mw) & ((64'd1 << ew) - 1);
    longint unsigned m = x & ((64'd1 << mw) - 1);
    real v;
    if (e == 0) v = real'(m) * (2.0 ** real'(1 - bias - mw));
    else        v = real'(m + (64'd1 << mw)) * (2.0 ** real'(int'(e) - bias - mw));
    return sign_of(x, w) ? -v : v;
  endfunction

  // a < b for non-NaN encodings, with -0 below +0.
  function automatic bit fp_lt(logic [63:0] a, logic [63:0] b, int w);
    real ra, rb;
    if (a == b) return 1'b0;
    if (is_inf(a, w)) return sign_of(a, w);
    if (is_inf(b, w)) return !sign_of(b, w);
    ra = to_real(a, w);
    rb = to_real(b, w);
    if (ra != rb) return ra < rb;
    return sign_of(a, w) && !sign_of(b, w);
  endfunction

  function automatic res_t model(req_t q);
    res_t r;
    int w;
    logic [63:0] a, b, x;
    r.vd = q.vd_old;
    r.ff = 5'd0;
    if (q.sew == 2'b00) return r;
    w = (q.sew == 2'b01) ? 16 : (q.sew == 2'b10) ? 32 : 64;
    for (int i = 0; i < VLEN / w; i++) begin
      if (!((i < int'(q.vl)) && (q.vm || q.v0[i]))) continue;
      a = get_e(q.vs2, i, w);
      b = get_e(q.vs1, i, w);
      if (is_snan(a, w) || is_snan(b, w)) r.ff[4] = 1'b1;
      if (is_nan(a, w) && is_nan(b, w))
        x = (w == 16) ? 64'h7E00 : (w == 32) ? 64'h7FC0_0000 : 64'h7FF8_0000_0000_0000;
      else if (is_nan(a, w)) x = b;
      else if (is_nan(b, w)) x = a;
      else if (q.op_max)     x = fp_lt(a, b, w) ? b : a;
      else                   x = fp_lt(a, b, w) ? a : b;
      r.vd = put_e(r.vd, i, w, x);
    end
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] gen_elem(int w, logic [63:0] other);
    int mw = man_w(w);
    int ew = w - 1 - mw;
    logic [63:0] emask = ((64'd1 << ew) - 1) << mw;
    logic [63:0] mmask = (64'd1 << mw) - 1;
    logic [63:0] wmask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 1);
    logic [63:0] rnd = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: return emask | (64'd1 << (mw - 1)) | (rnd & mmask);
      1: return emask | (rnd & (mmask >> 1)) | 64'd1;
      2: return rnd[0] ? (64'd1 << (w - 1)) : 64'd0;
      3: return other;
      4: return emask | ({63'd0, rnd[0]} << (w - 1));
      default: return rnd & wmask;
    endcase
  endfunction

  function automatic req_t gen_random();
    req_t q;
    int w;
    logic [63:0] a, b;
    q.op_max = 1'($urandom_range(0, 1));
    q.sew    = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    q.vl     = VLW'($urandom_range(0, 15));
    q.vm     = 1'($urandom_range(0, 1));
    q.v0     = 8'($urandom);
    q.vd_old = {$urandom, $urandom, $urandom, $urandom};
    q.vs2    = {$urandom, $urandom, $urandom, $urandom};
    q.vs1    = {$urandom, $urandom, $urandom, $urandom};
    if (q.sew != 2'b00) begin
      w = 16 << (q.sew - 1);
      for (int i = 0; i < VLEN / w; i++) begin
        b = gen_elem(w, {$urandom, $urandom});
        a = gen_elem(w, b);
        q.vs1 = put_e(q.vs1, i, w, b);
        q.vs2 = put_e(q.vs2, i, w, a);
      end
    end
    return q;
  endfunction

  function automatic req_t mk(logic op, logic [1:0] s, logic [VLW-1:0] l, logic m, logic [7:0] mask,
                              logic [VLEN-1:0] a, logic [VLEN-1:0] b, logic [VLEN-1:0] old);
    req_t q;
    q.op_max = op; q.sew = s; q.vl = l; q.vm = m; q.v0 = mask;
    q.vs2 = a; q.vs1 = b; q.vd_old = old;
    return q;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offer one operation until every instance accepts it.
  task automatic send(input req_t q, input res_t e);
    int waited = 0;
    bit done = 1'b0;
    cur = q;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clock);
      if (&in_ready_a) begin
        @(posedge clock);
        exp_mem[wr_ptr] = e;
        wr_ptr++;
        #1;
        in_valid = 1'b0;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        done = 1'b1;
      end else begin
        step();
        waited++;
        if (waited > 200) begin
          checks++; errors++;
          $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 111", in_ready_a, waited);
          in_valid = 1'b0;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    if (!rand_ready) out_ready = 1'b1;
    while ((rd_ptr[0] != wr_ptr || rd_ptr[1] != wr_ptr || rd_ptr[2] != wr_ptr) && t < 500) begin
      step();
      t++;
    end
    for (int d = 0; d < 3; d++) chk($sformatf("drained_count dut%0d", d), VLEN'(rd_ptr[d]), VLEN'(wr_ptr));
  endtask

  // After an acceptance with an empty pipe, out_valid rises exactly STAGES-1 edges later.
  task automatic latency_check(input string tag);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      for (int d = 0; d < 3; d++)
        chk($sformatf("%s_latency dut%0d edge+%0d", tag, d, k), VLEN'(out_valid_a[d]), VLEN'(k == d + 1));
    end
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: a transfer is committed when out_valid && out_ready ahead of the edge.
  task automatic monitor();
    forever begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        if (!reset_n) rd_ptr[d] = wr_ptr;
        else if (out_valid_a[d] && out_ready) begin
          if (rd_ptr[d] >= wr_ptr) begin
            checks++; errors++;
            $display("FAIL extra_output dut%0d: got vd %h, expected no output", d, vd_a[d]);
          end else begin
            chk($sformatf("vd dut%0d op%0d", d, rd_ptr[d]), vd_a[d], exp_mem[rd_ptr[d]].vd);
            chk($sformatf("fflags dut%0d op%0d", d, rd_ptr[d]), VLEN'(ff_a[d]), VLEN'(exp_mem[rd_ptr[d]].ff));
            rd_ptr[d]++;
          end
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_out_valid dut%0d", tag, d), VLEN'(out_valid_a[d]), '0);
      chk($sformatf("%s_vd dut%0d", tag, d), vd_a[d], '0);
      chk($sformatf("%s_fflags dut%0d", tag, d), VLEN'(ff_a[d]), '0);
      chk($sformatf("%s_in_ready dut%0d", tag, d), VLEN'(in_ready_a[d]), VLEN'(1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

  initial begin
    req_t q;
    fork monitor(); join_none

    tbl[0].q = mk(0, 2'b10, 4, 1, 8'hFF, 128'h40600000_00000000_C0000000_3F800000,
                  128'h40600000_80000000_C0400000_40000000, '0);
    tbl[0].e = '{vd: 128'h40600000_80000000_C0400000_3F800000, ff: 5'h00};
    tbl[1].q = mk(1, 2'b11, 2, 1, 8'h00, 128'h7FF0000000000001_7FF8000000000001,
                  128'h7FF0000000000002_3FF0000000000000, '0);
    tbl[1].e = '{vd: 128'h7FF8000000000000_3FF0000000000000, ff: 5'h10};
    tbl[2].q = mk(0, 2'b01, 5, 0, 8'h15, 128'h3C00_3C00_3C00_4000_3C00_C000_7C01_3C00,
                  128'h0000_0000_0000_4200_0000_3C00_3C00_4000, {8{16'hAAAA}});
    tbl[2].e = '{vd: 128'hAAAA_AAAA_AAAA_4000_AAAA_C000_AAAA_3C00, ff: 5'h00};
    tbl[3].q = mk(1, 2'b00, 15, 1, 8'hFF, {2{64'h7FF0000000000001}}, {2{64'h7FF0000000000001}},
                  128'h0123456789ABCDEF_FEDCBA9876543210);
    tbl[3].e = '{vd: 128'h0123456789ABCDEF_FEDCBA9876543210, ff: 5'h00};
    tbl[4].q = mk(0, 2'b10, 0, 1, 8'hFF, {4{32'h7F800001}}, {4{32'h3F800000}},
                  128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    tbl[4].e = '{vd: 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, ff: 5'h00};
    tbl[5].q = mk(1, 2'b11, 15, 1, 8'h00, 128'hBFF0000000000000_3FF0000000000000,
                  128'hBFE0000000000000_4000000000000000, '0);
    tbl[5].e = '{vd: 128'hBFE0000000000000_4000000000000000, ff: 5'h00};
    tbl[6].q = mk(1, 2'b01, 1, 1, 8'h00, 128'h1111_1111_1111_1111_1111_1111_1111_8000,
                  128'h2222_2222_2222_2222_2222_2222_2222_0000, {8{16'h5555}});
    tbl[6].e = '{vd: 128'h5555_5555_5555_5555_5555_5555_5555_0000, ff: 5'h00};
    tbl[7].q = mk(0, 2'b10, 2, 1, 8'h00, 128'h00000000_00000000_7F800001_7FC00001,
                  128'h00000000_00000000_3F800000_FFC00000, 128'h11111111_22222222_33333333_44444444);
    tbl[7].e = '{vd: 128'h11111111_22222222_3F800000_7FC00000, ff: 5'h10};
    tbl[8].q = mk(0, 2'b11, 2, 0, 8'h02, 128'hC000000000000000_0000000000000000,
                  128'h4000000000000000_8000000000000000, {{16{4'hA}}, {16{4'hB}}});
    tbl[8].e = '{vd: 128'hC000000000000000_BBBBBBBBBBBBBBBB, ff: 5'h00};

    // Reset state
    #3;
    check_idle_outputs("reset");
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    step();

    // First-transaction latency
    send(tbl[0].q, tbl[0].e);
    latency_check("first");
    drain();

    // Directed vectors, back-to-back
    for (int i = 0; i < 9; i++) send(tbl[i].q, tbl[i].e);
    drain();

    // Back-pressure: 6 ops streamed, out_ready low for 3 cycles after the 4th
    for (int j = 0; j < 6; j++) begin
      q = gen_random();
      send(q, model(q));
      if (j == 3) begin
        out_ready = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("stall_in_ready dut%0d", d), VLEN'(in_ready_a[d]), '0);
        for (int c = 0; c < 3; c++) begin
          @(posedge clock); #1;
          for (int d = 0; d < 3; d++) begin
            chk($sformatf("stall_out_valid dut%0d c%0d", d, c), VLEN'(out_valid_a[d]), VLEN'(1));
            chk($sformatf("stall_in_ready dut%0d c%0d", d, c), VLEN'(in_ready_a[d]), '0);
          end
        end
        out_ready = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("release_in_ready dut%0d", d), VLEN'(in_ready_a[d]), VLEN'(1));
      end
    end
    drain();

    // Randomized traffic with random back-pressure and gaps
    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) step();
      q = gen_random();
      send(q, model(q));
    end
    rand_ready = 1'b0;
    drain();

    // Asynchronous reset with two operations in flight
    q = gen_random(); send(q, model(q));
    q = gen_random(); send(q, model(q));
    #1;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    step();
    send(tbl[1].q, tbl[1].e);
    latency_check("post_reset");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
